game_status: RTL

Session bookkeeping block that feeds the stage controller. It tracks player HP, kill count, round timer and post-hit invulnerability, and raises `gameover` for the stage FSM. It consumes the registered `stage` code, the 1-cycle gameplay event pulses from the collision/enemy logic, and its own second prescaler. It sits between gameplay logic (producers of `kill_pulse`/`hit_pulse`) and the stage controller (consumer of `gameover`/`kills`); `hp`, `time_left` and `invuln` also go to the display.

---
 rtl/game_status.sv | 86 ++++++++
 1 files changed

// File: rtl/game_status.sv
// game_status: HP, kills, round timer and invulnerability bookkeeping for the stage controller
module game_status #(
  parameter int MAX_HP        = 3,
  parameter int INVULN_CYCLES = 50_000_000,
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int TIME_LIMIT    = 180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] stage,
  input  logic       kill_pulse,
  input  logic       hit_pulse,
  output logic [7:0] kills,
  output logic [3:0] hp,
  output logic [7:0] time_left,
  output logic       invuln,
  output logic       gameover
);
  localparam int CW = $clog2(INVULN_CYCLES + 1);
  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [CW-1:0] INV_LOAD = CW'(INVULN_CYCLES);
  localparam logic [PW-1:0] PSC_TOP = PW'(TICKS_PER_SEC - 1);
  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [PW-1:0] psc, psc_n;
  logic [7:0] kills_n, time_n;
  logic [3:0] hp_n;
  logic invuln_n, gameover_n, hit_ok, tick;
  // next values: title loads, play advances, everything else (over, stalls) holds
  always_comb begin
    state_n = state;
    kills_n = kills;
    hp_n = hp;
    time_n = time_left;
    cnt_n = cnt;
    psc_n = psc;
    invuln_n = invuln;
    gameover_n = gameover;
    hit_ok = hit_pulse && cnt <= CW'(1);
    tick = psc == PSC_TOP;
    if (stage == 4'h0 || state == IDLE) begin
      state_n = stage == 4'h1 ? PLAY : IDLE;
      kills_n = '0;
      hp_n = 4'(MAX_HP);
      time_n = 8'(TIME_LIMIT);
      cnt_n = '0;
      psc_n = '0;
      invuln_n = 1'b0;
      gameover_n = 1'b0;
    end else if (state == PLAY && stage == 4'h1) begin
      kills_n = kills + 8'(kill_pulse && kills != 8'hff);
      hp_n = hit_ok ? hp - 4'd1 : hp;
      cnt_n = hit_ok ? INV_LOAD : cnt != '0 ? cnt - CW'(1) : cnt;
      invuln_n = hit_ok || cnt > CW'(1);
      psc_n = tick ? '0 : psc + PW'(1);
      time_n = tick && time_left != 8'd0 ? time_left - 8'd1 : time_left;
      if (hp_n == 4'd0 || time_n == 8'd0) begin
        gameover_n = 1'b1;
        state_n = OVER;
      end
    end
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      kills <= '0;
      hp <= 4'(MAX_HP);
      time_left <= 8'(TIME_LIMIT);
      cnt <= '0;
      psc <= '0;
      invuln <= 1'b0;
      gameover <= 1'b0;
    end else begin
      state <= state_n;
      kills <= kills_n;
      hp <= hp_n;
      time_left <= time_n;
      cnt <= cnt_n;
      psc <= psc_n;
      invuln <= invuln_n;
      gameover <= gameover_n;
    end
  end
endmodule
